// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: instruction word, opcodes,
// in-flight tag record and a small pointer helper.
package alu_arbiter_pkg;

  localparam int ALU_RESULT_W = 32;
  localparam int OPERAND_W    = 32;
  // Tag ids are a fixed 3 bits so one tag type serves every NUM_REQ up to 8.
  localparam int TAG_ID_W     = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_SHR  = 3'd6,
    OP_PASS = 3'd7
  } opcode_t;

  typedef struct packed {
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
    opcode_t              opcode;
  } instruction_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } alu_tag_t;

  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 32'sd1;
    if (nxt >= n) begin
      nxt = 32'sd0;
    end else begin
      nxt = nxt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr.sv
// Reusable round-robin arbiter: one-hot grant starting the search at a
// rotating pointer that moves past the winner whenever a grant is taken.
module rr_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   cand;

  // Search req from ptr upward (mod N); nothing is granted while in reset.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    if (!reset) begin
      for (int off = 0; off < N; off++) begin
        cand = {1'b0, ptr} + (IDX_W+1)'(off);
        if (cand >= (IDX_W+1)'(N)) begin
          cand = cand - (IDX_W+1)'(N);
        end else begin
          cand = cand;
        end
        if (!grant_valid && req[cand[IDX_W-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[IDX_W-1:0];
        end else begin
          grant_valid = grant_valid;
        end
      end
      if (grant_valid) begin
        grant[grant_idx] = 1'b1;
      end else begin
        grant = '0;
      end
    end else begin
      grant_valid = 1'b0;
    end
  end

  // Pointer moves to the slot after the winner only when the grant is used.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (advance && grant_valid) begin
      ptr <= IDX_W'(wrap_inc(int'(grant_idx), N));
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one fixed-latency ALU between NUM_REQ requesters; a tag pipeline
// routes each result back to the requester that issued the word.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  instruction_t            req_iw [NUM_REQ],
  output logic [NUM_REQ-1:0]      req_ready,
  output instruction_t            alu_iw,
  input  logic [ALU_RESULT_W-1:0] alu_result,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [ALU_RESULT_W-1:0] rsp_result,
  output logic                    busy
);

  localparam int DEPTH = ALU_LATENCY + 1;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_valid;
  logic               transfer;
  alu_tag_t           tag_pipe [DEPTH];
  alu_tag_t           tag_next [DEPTH];
  logic               busy_next;
  logic               out_valid;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (req_valid),
    .advance     (transfer),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // A grant is only ever raised on a valid request, so every grant is a transfer.
  assign req_ready = grant;
  assign transfer  = grant_valid;

  // Issue register: holds the last word when idle; the ALU's stale result is untagged.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_iw <= '0;
    end else if (transfer) begin
      alu_iw <= req_iw[grant_idx];
    end else begin
      alu_iw <= alu_iw;
    end
  end

  // Next tag pipe contents and the in-flight indication derived from them.
  always_comb begin
    busy_next         = 1'b0;
    tag_next[0].valid = transfer;
    tag_next[0].id    = TAG_ID_W'(grant_idx);
    for (int s = 1; s < DEPTH; s++) begin
      tag_next[s] = tag_pipe[s-1];
    end
    for (int s = 0; s < DEPTH; s++) begin
      busy_next = busy_next | tag_next[s].valid;
    end
  end

  // Tag pipeline advances every cycle; reset drops everything in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_pipe[s] <= '0;
      end
      busy <= 1'b0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        tag_pipe[s] <= tag_next[s];
      end
      busy <= busy_next;
    end
  end

  // Reset masks the final stage so a word issued before reset never responds.
  assign out_valid = tag_pipe[DEPTH-1].valid & ~reset;

  // Final stage lines up with the ALU result register, so the result passes straight through.
  always_comb begin
    if (out_valid) begin
      rsp_valid  = 1'b1;
      rsp_id     = ID_W'(tag_pipe[DEPTH-1].id);
      rsp_result = alu_result;
    end else begin
      rsp_valid  = 1'b0;
      rsp_id     = '0;
      rsp_result = '0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a registered ALU model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int ALU_LATENCY = 1;
  localparam int ID_W        = 2;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    opcode_t     op;
    logic        step;   // when set, requester i presents a + i
    logic [3:0]  rdy;
    logic        rv;
    logic [1:0]  rid;
    logic [31:0] res;
    logic        bsy;
  } vec_t;

  logic               clock;
  logic               reset;
  logic [NUM_REQ-1:0] req_valid;
  instruction_t       req_iw [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;
  instruction_t       alu_iw;
  logic [31:0]        alu_result = 32'd0;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [31:0]        rsp_result;
  logic               busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t tbl[$];
  instruction_t exp_iw;

  alu_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ALU_LATENCY (ALU_LATENCY),
    .ID_W        (ID_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_iw     (req_iw),
    .req_ready  (req_ready),
    .alu_iw     (alu_iw),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] alu_model(input instruction_t w);
    case (w.opcode)
      OP_ADD:  return w.a + w.b;
      OP_SUB:  return w.a - w.b;
      OP_AND:  return w.a & w.b;
      OP_OR:   return w.a | w.b;
      OP_XOR:  return w.a ^ w.b;
      OP_SHL:  return w.a << w.b[4:0];
      OP_SHR:  return w.a >> w.b[4:0];
      OP_PASS: return w.a;
      default: return 32'd0;
    endcase
  endfunction

  // Single-cycle registered ALU, as the arbiter expects for ALU_LATENCY = 1.
  always @(posedge clock) alu_result <= alu_model(alu_iw);

  function automatic instruction_t word_of(input vec_t v, input int i);
    instruction_t w;
    w.a      = v.a + (v.step ? 32'(i) : 32'd0);
    w.b      = v.b;
    w.opcode = v.op;
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add_row(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                         input opcode_t op, input logic step, input logic [3:0] rdy,
                         input logic rv, input logic [1:0] rid, input logic [31:0] res,
                         input logic bsy);
    vec_t v;
    v.valid = valid; v.a = a; v.b = b; v.op = op; v.step = step;
    v.rdy = rdy; v.rv = rv; v.rid = rid; v.res = res; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                       input opcode_t op);
    vec_t v;
    v.valid = valid; v.a = a; v.b = b; v.op = op; v.step = 1'b0;
    v.rdy = 4'd0; v.rv = 1'b0; v.rid = 2'd0; v.res = 32'd0; v.bsy = 1'b0;
    req_valid = valid;
    for (int i = 0; i < NUM_REQ; i++) req_iw[i] = word_of(v, i);
  endtask

  initial begin
    // Full contention from pointer 0: grants 0,1,2,3,0,1,2,3, results 10+i.
    add_row(4'b1111, 32'd0, 32'd10, OP_ADD, 1'b1, 4'b0001, 1'b0, 2'd0, 32'd0,  1'b0);
    add_row(4'b1111, 32'd0, 32'd10, OP_ADD, 1'b1, 4'b0010, 1'b0, 2'd0, 32'd0,  1'b1);
    add_row(4'b1111, 32'd0, 32'd10, OP_ADD, 1'b1, 4'b0100, 1'b1, 2'd0, 32'd10, 1'b1);
    add_row(4'b1111, 32'd0, 32'd10, OP_ADD, 1'b1, 4'b1000, 1'b1, 2'd1, 32'd11, 1'b1);
    add_row(4'b1111, 32'd0, 32'd10, OP_ADD, 1'b1, 4'b0001, 1'b1, 2'd2, 32'd12, 1'b1);
    add_row(4'b1111, 32'd0, 32'd10, OP_ADD, 1'b1, 4'b0010, 1'b1, 2'd3, 32'd13, 1'b1);
    add_row(4'b1111, 32'd0, 32'd10, OP_ADD, 1'b1, 4'b0100, 1'b1, 2'd0, 32'd10, 1'b1);
    add_row(4'b1111, 32'd0, 32'd10, OP_ADD, 1'b1, 4'b1000, 1'b1, 2'd1, 32'd11, 1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd2, 32'd12, 1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd3, 32'd13, 1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b0);
    // Single request: req 0 sends 5+7.
    add_row(4'b0001, 32'd5, 32'd7,  OP_ADD, 1'b0, 4'b0001, 1'b0, 2'd0, 32'd0,  1'b0);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd0, 32'd12, 1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b0);
    // Back-to-back req 2, a=k, b=1, pointer starting at 1.
    add_row(4'b0100, 32'd0, 32'd1,  OP_ADD, 1'b0, 4'b0100, 1'b0, 2'd0, 32'd0,  1'b0);
    add_row(4'b0100, 32'd1, 32'd1,  OP_ADD, 1'b0, 4'b0100, 1'b0, 2'd0, 32'd0,  1'b1);
    add_row(4'b0100, 32'd2, 32'd1,  OP_ADD, 1'b0, 4'b0100, 1'b1, 2'd2, 32'd1,  1'b1);
    add_row(4'b0100, 32'd3, 32'd1,  OP_ADD, 1'b0, 4'b0100, 1'b1, 2'd2, 32'd2,  1'b1);
    add_row(4'b0100, 32'd4, 32'd1,  OP_ADD, 1'b0, 4'b0100, 1'b1, 2'd2, 32'd3,  1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd2, 32'd4,  1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd2, 32'd5,  1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b0);
    // Pointer at 3, only req 1: wraps and skips; then req 1 and 3 with pointer at 2.
    add_row(4'b0010, 32'd20, 32'd5, OP_SUB, 1'b0, 4'b0010, 1'b0, 2'd0, 32'd0,  1'b0);
    add_row(4'b1010, 32'd100, 32'd1, OP_ADD, 1'b1, 4'b1000, 1'b0, 2'd0, 32'd0, 1'b1);
    add_row(4'b1010, 32'd100, 32'd1, OP_ADD, 1'b1, 4'b0010, 1'b1, 2'd1, 32'd15, 1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd3, 32'd104, 1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd1, 32'd102, 1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b0);
    // Idle gaps: two isolated requests, no spurious responses between them.
    add_row(4'b0001, 32'hF0, 32'h3C, OP_AND, 1'b0, 4'b0001, 1'b0, 2'd0, 32'd0, 1'b0);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h30, 1'b1);
    add_row(4'b1000, 32'hFF, 32'h0F, OP_XOR, 1'b0, 4'b1000, 1'b0, 2'd0, 32'd0, 1'b0);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b1, 2'd3, 32'hF0, 1'b1);
    add_row(4'b0000, 32'd0, 32'd0,  OP_ADD, 1'b0, 4'b0000, 1'b0, 2'd0, 32'd0,  1'b0);

    // Reset state, with every requester valid to show no grant during reset.
    reset = 1'b1;
    drive(4'b0000, 32'd0, 32'd0, OP_ADD);
    repeat (2) @(posedge clock);
    @(negedge clock);
    drive(4'b1111, 32'd1, 32'd1, OP_ADD);
    #1;
    check("reset req_ready", req_ready, 4'b0000);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_id", rsp_id, 2'd0);
    check("reset rsp_result", rsp_result, 32'd0);
    check("reset busy", busy, 1'b0);
    check("reset alu_iw", alu_iw, 67'd0);

    exp_iw = '0;
    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clock);
      reset = 1'b0;
      req_valid = tbl[r].valid;
      for (int i = 0; i < NUM_REQ; i++) req_iw[i] = word_of(tbl[r], i);
      #1;
      check($sformatf("row%0d req_ready", r), req_ready, tbl[r].rdy);
      check($sformatf("row%0d rsp_valid", r), rsp_valid, tbl[r].rv);
      check($sformatf("row%0d busy", r), busy, tbl[r].bsy);
      check($sformatf("row%0d alu_iw", r), alu_iw, exp_iw);
      if (tbl[r].rv) begin
        check($sformatf("row%0d rsp_id", r), rsp_id, tbl[r].rid);
        check($sformatf("row%0d rsp_result", r), rsp_result, tbl[r].res);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (tbl[r].rdy[i]) exp_iw = word_of(tbl[r], i);
    end

    // Reset mid-flight: two words issued, reset lands before either responds.
    @(negedge clock); drive(4'b0011, 32'd7, 32'd3, OP_ADD); #1;
    check("mid first grant", req_ready, 4'b0001);
    @(negedge clock); drive(4'b0011, 32'd7, 32'd3, OP_ADD); #1;
    check("mid second grant", req_ready, 4'b0010);
    check("mid no early rsp", rsp_valid, 1'b0);
    @(negedge clock); reset = 1'b1; drive(4'b1111, 32'd7, 32'd3, OP_ADD); #1;
    check("mid reset req_ready", req_ready, 4'b0000);
    check("mid reset rsp_valid", rsp_valid, 1'b0);
    @(negedge clock); reset = 1'b0; drive(4'b0000, 32'd0, 32'd0, OP_ADD); #1;
    check("post reset rsp_valid", rsp_valid, 1'b0);
    check("post reset rsp_id", rsp_id, 2'd0);
    check("post reset rsp_result", rsp_result, 32'd0);
    check("post reset busy", busy, 1'b0);
    check("post reset alu_iw", alu_iw, 67'd0);
    check("post reset req_ready", req_ready, 4'b0000);
    @(negedge clock); #1;
    check("post reset no rsp", rsp_valid, 1'b0);
    check("post reset still idle", busy, 1'b0);
    @(negedge clock); drive(4'b1111, 32'd40, 32'd2, OP_SUB); #1;
    check("post reset pointer 0", req_ready, 4'b0001);
    @(negedge clock); drive(4'b0000, 32'd0, 32'd0, OP_ADD); #1;
    check("post reset busy up", busy, 1'b1);
    @(negedge clock); #1;
    check("post reset rsp_valid", rsp_valid, 1'b1);
    check("post reset rsp_id", rsp_id, 2'd0);
    check("post reset rsp_result", rsp_result, 32'd38);
    @(negedge clock); #1;
    check("post reset drained", rsp_valid, 1'b0);
    check("post reset busy down", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between NUM_REQ requesters using round-robin arbitration.
- Each requester offers an instruction_t word over a valid/ready handshake. The arbiter issues at most one word per cycle to the ALU.
- A tag pipeline tracks each issued word, so every result returns to its requester after the ALU's fixed latency.
- Sits between requesting engines and the ALU's IW/result ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ALU_LATENCY, 1, clocks from an IW word being presented at a clock edge to its result being valid on alu_result (ALU registers on clock).
- ID_W, $clog2(NUM_REQ), requester-ID width.

Ports:
- clock  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_iw  in  NUM_REQ x instruction_t  per-requester instruction word (a, b, opcode).
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] && req_ready[i].
- alu_iw  out  instruction_t  registered word driven to ALU IW.
- alu_result  in  32  ALU result.
- rsp_valid  out  1  rsp_result/rsp_id valid this cycle.
- rsp_id  out  ID_W  requester that owns rsp_result.
- rsp_result  out  32  result returned.
- busy  out  1  at least one issued word is still in flight.

Behaviour:
- Reset values: alu_iw = '0, rsp_valid = 0, rsp_id = 0, rsp_result = 0, busy = 0, priority pointer = 0, tag pipeline valids cleared.
- Reset mid-operation: in-flight words are dropped. No rsp_valid is asserted for any word issued before reset. The first cycle after reset is clean.
- Arbitration (combinational per cycle):
  - Starting at pointer p, pick the first i (mod NUM_REQ) with req_valid[i]=1.
  - req_ready is one-hot on that i, or all-zero if no request. req_ready is never asserted during reset.
  - No backpressure exists from the ALU, so a grant is possible every cycle.
- Pointer update: on a transfer to i, p <= (i+1) mod NUM_REQ. With no transfer, p holds. Wrap from NUM_REQ-1 to 0 is required.
- Issue: on a transfer, alu_iw <= req_iw[i] at that clock edge, and stage 0 of the tag pipe gets {valid=1, id=i}.
  - With no transfer, alu_iw holds its previous value and stage 0 valid = 0.
  - The ALU may recompute on a stale IW; the result is ignored because its tag valid = 0.
- Tag pipeline: depth ALU_LATENCY+1 shift register of {valid, id}, advancing every cycle.
- Response:
  - rsp_valid/rsp_id are taken from the final stage.
  - rsp_result = alu_result, sampled in the cycle the final-stage valid is 1. It is combinational from alu_result when aligned; alternatively register both sides, but total latency is fixed as below.
  - Total latency: handshake cycle N -> rsp_valid in cycle N+1+ALU_LATENCY.
  - Responses return in issue order, one per cycle max. There is no response backpressure; requesters must accept.
- busy = OR of all tag-pipe valids.
- Fairness:
  - With all requesters continuously valid, grants cycle 0,1,2,3,0,…
  - A single continuously-valid requester is granted every cycle (full throughput).
- Simultaneous events: a requester dropping valid in the same cycle as grant evaluation has no transfer, and the pointer is unchanged. A new grant and a response for an older word in the same cycle are independent.
- Width rules: results are passed unmodified (32 bits); no arithmetic is performed by this block.

Decomposition:
- The definitions package already holds instruction_t and the opcode enum.
- Add to it: ALU_RESULT_W = 32 and a typedef alu_tag_t {logic valid; logic [ID_W-1:0] id;}, or a fixed 3-bit id for NUM_REQ ≤ 8.
- One sub-module is natural: rr_arbiter (NUM_REQ), containing the request vector, pointer, one-hot grant and grant index. It is reusable elsewhere.
- The tag pipeline and response stay in alu_arbiter.

Test Plan:
- Single request: req 0 sends {a=5, b=7, ADD} in cycle 2 -> req_ready[0]=1 in cycle 2, alu_iw updated at the edge, rsp_valid=1, rsp_id=0, rsp_result=12 in cycle 2+1+ALU_LATENCY.
- Full contention: all 4 valid for 8 cycles, each with a distinct ADD (a=i, b=10) -> grant order 0,1,2,3,0,1,2,3; responses in the same order with results 10,11,12,13 repeated; busy held high.
- Back-to-back same requester: req 2 valid 5 cycles with ADD a=k, b=1, k=0..4 -> 5 consecutive grants, responses id=2 with results 1..5 on consecutive cycles.
- Pointer wrap and skip: pointer at 3, only req 1 valid -> req 1 granted and pointer becomes 2; next, req 1 and req 3 both valid -> req 3 granted first.
- Reset mid-flight: issue 2 words, then assert reset for 1 cycle before their responses -> no rsp_valid for those words; all outputs at reset values; pointer = 0; busy = 0.
- Idle gaps: requests in cycles 1 and 4 only -> exactly two rsp_valid pulses with correct ids; no spurious rsp_valid in between.
